fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of `IMem`. Holds the program counter, issues one word read per cycle to `IMem` through its `req`/`addr` port, and captures the returned instruction one cycle later with its PC. Entries go into a small prefetch FIFO that feeds decode over a valid/ready handshake. Also handles redirects (branch/jump) and address/alignment faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `ADDR_W`, default `memory_pkg::MEM_ADDR_WIDTH`: instruction address width.
- `WORD_W`, default `memory_pkg::MEM_WORD_WIDTH`: instruction width.
- `FIFO_DEPTH`, default 2: prefetch entries. Power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: read request to `IMem` `req`.
- `imem_addr` out ADDR_W: read address to `IMem` `addr`.
- `imem_addr_err` in 1: `IMem` address error, valid with `imem_data`.
- `imem_data` in WORD_W: `IMem` read data, valid the cycle after `imem_req`.
- `redirect_valid` in 1: load a new PC, flush everything.
- `redirect_pc` in ADDR_W: redirect target.
- `inst_valid` out 1: FIFO head valid.
- `inst_ready` in 1: decode accepts head.
- `inst_data` out WORD_W: head instruction.
- `inst_pc` out ADDR_W: head instruction PC.
- `fetch_fault` out 1: sticky fault flag, held while in FAULT.
- `fault_pc` out ADDR_W: address that caused the fault.
- `perf_fetch_cnt` out 32: instructions delivered to decode (see Configuration).

## Operation
- States:
  - RUN: the state entered from reset.
  - FAULT: reached from RUN on an error response or a misaligned redirect. Left only by an aligned redirect.
- PC register: resets to RESET_PC. Increments by 4 on each issued request. Loaded with `redirect_pc` on redirect.
- Issue rule, evaluated in RUN only:
  - `imem_req`=1 when `occupancy + inflight - pop < FIFO_DEPTH`.
  - `pop` = `inst_valid & inst_ready`.
  - `inflight` ≤ 1.
  - `imem_addr` = PC.
- Response: the cycle after a request, `imem_data` and the request PC are pushed into the FIFO, unless the response is killed or `imem_addr_err`=1.
- Error response:
  - No push.
  - Go to FAULT; `fault_pc` = request PC; no further requests.
  - Entries already in the FIFO still drain to decode.
- Redirect, with `redirect_valid`=1 in cycle N:
  - FIFO flushed at end of N.
  - Any in-flight response arriving in N+1 is dropped (kill flag).
  - PC = `redirect_pc`.
  - `imem_req` is 0 in N; the first request goes out in N+1.
- Misaligned redirect (`redirect_pc[1:0]`≠0): FIFO flushed, go to FAULT, `fault_pc` = `redirect_pc`.
- Aligned redirect while in FAULT: return to RUN and clear `fetch_fault`.
- Simultaneous events:
  - Redirect beats pop, push and error response in the same cycle. A popped head counts as consumed; nothing is pushed.
  - Push and pop in the same cycle keep occupancy unchanged.
- FIFO head is registered storage: `inst_data`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fetch_fault`=0, `fault_pc`=0, `perf_fetch_cnt`=0. State=RUN, FIFO empty, inflight=0.
- Reset released in cycle R: first `imem_req` in cycle R+1 with `imem_addr`=RESET_PC.
- Request in cycle N → push at end of N+1 → `inst_valid` in N+2. Fetch-to-decode latency is 2 cycles.
- Steady state with `inst_ready`=1: one instruction per cycle, consecutive PCs, no bubbles.
- Redirect in cycle N (empty pipeline otherwise): target instruction valid at N+3.
- `rst_n`=0 mid-operation: at the next edge all state returns to reset values and in-flight data is discarded.
- Error response in cycle N+1: `fetch_fault`=1 from N+2.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- Defined: `perf_fetch_cnt` increments by 1 on every pop. It wraps modulo 2^32 and clears on reset and on nothing else.
- Undefined: the counter is not built and `perf_fetch_cnt` is tied to 0.

## Test plan
- Reset release, `inst_ready`=1, memory holding sequential words: requests at 0x0, 0x4, 0x8, …; first `inst_valid` 2 cycles after the first request; then one instruction per cycle with `inst_pc` matching.
- `inst_ready`=0 for 5 cycles: FIFO fills to 2; `imem_req` drops to 0; head is stable; on release, no instruction is lost or duplicated.
- Redirect to 0x40 while the FIFO is full and a request is in flight: FIFO flushed; stale response dropped; next `imem_addr`=0x40; next `inst_pc`=0x40.
- Redirect to 0x42: `fetch_fault`=1, `fault_pc`=0x42, no requests. Then redirect to 0x80: back to RUN and fetching from 0x80.
- Fetch walks to an address that makes `IMem` raise `addr_err` (e.g. 0x10000): `fault_pc`=0x10000; earlier buffered entries still delivered; `imem_req` stays 0.
- With `FETCH_PERF_CNT_EN`: `perf_fetch_cnt` equals the number of handshakes (e.g. 20 after 20 pops). Without it: `perf_fetch_cnt` is always 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-deep IMem request pipeline, prefetch FIFO toward decode.
// Optional feature macro: FETCH_PERF_CNT_EN (delivered-instruction counter).
package memory_pkg;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_WORD_WIDTH = 32;
endpackage

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_W     = memory_pkg::MEM_ADDR_WIDTH,
    parameter int          WORD_W     = memory_pkg::MEM_WORD_WIDTH,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_addr_err,
    input  logic [WORD_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [31:0]       perf_fetch_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              vld_p1;
    logic              kill_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              pop, push, rsp_live, rsp_err, redir_bad, req;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    // A redirect in the response cycle wins over both the push and the error.
    assign rsp_live   = vld_p1 & ~kill_p1 & ~redirect_valid;
    assign rsp_err    = rsp_live & imem_addr_err;
    assign push       = rsp_live & ~imem_addr_err;
    assign redir_bad  = redirect_valid & (redirect_pc[1:0] != 2'b00);

    always_comb begin
        req       = 1'b0;
        state_nxt = state;
        if (rst_n && (state == RUN) && !redirect_valid && !rsp_err &&
            ((int'(count) + int'(vld_p1)) < (FIFO_DEPTH + int'(pop))))
            req = 1'b1;
        if (redirect_valid)
            state_nxt = redir_bad ? FAULT : RUN;
        else if (rsp_err)
            state_nxt = FAULT;
    end

    assign imem_req    = req;
    assign imem_addr   = pc;
    assign fetch_fault = (state == FAULT);
    assign inst_data   = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc     = inst_valid ? fifo_pc[rd_ptr]   : '0;

    // p0 -> p1: request issue; FIFO control and fault tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= ADDR_W'(RESET_PC);
            vld_p1   <= 1'b0;
            kill_p1  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault_pc <= '0;
        end else begin
            state   <= state_nxt;
            vld_p1  <= req;
            kill_p1 <= redirect_valid;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (req)
                pc <= pc + ADDR_W'(4);
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
            if (redir_bad)
                fault_pc <= redirect_pc;
            else if (rsp_err)
                fault_pc <= pc_p1;
        end
    end

    // p1 -> FIFO: response capture alongside its request PC
    always_ff @(posedge clk) begin
        pc_p1 <= pc;
        if (push) begin
            fifo_data[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]   <= pc_p1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if (pop)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_fetch_cnt = perf_cnt;
`else
    assign perf_fetch_cnt = 32'd0;
`endif

endmodule
